// File: rtl/grant_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grant_decoder_pkg
//  Description : Shared FSM state encoding and field widths for grant_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package grant_decoder_pkg;

    localparam int IDX_W   = 2;
    localparam int GRANT_W = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage : grant_decoder_pkg
`default_nettype wire

// File: rtl/grant_decoder_dec2to4.sv
`default_nettype none
// ============================================================================
//  Module      : dec2to4
//  Description : Combinational 2-bit index to 4-bit one-hot decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec2to4
    import grant_decoder_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [GRANT_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule : dec2to4
`default_nettype wire

// File: rtl/grant_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : grant_decoder
//  Description : Turns an encoded request into a timed one-hot grant followed
//                by a forced idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_zero,
    // "release" is a reserved word, hence the suffix
    input  logic               release_pulse,
    output logic [GRANT_W-1:0] grant,
    output logic               busy,
    output logic               empty_seen
);

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] w_grant_nxt;
    logic               r_empty_seen;
    logic               w_empty_nxt;
    logic [GRANT_W-1:0] w_onehot;

    dec2to4 u_dec (
        .idx    (in_idx),
        .onehot (w_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_empty_seen <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_empty_seen <= w_empty_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_empty_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (in_zero) begin
                        w_empty_nxt = 1'b1;
                    end else begin
                        w_state_nxt = GRANT;
                        w_grant_nxt = w_onehot;
                        w_cnt_nxt   = c_hold_load;
                    end
                end
            end
            GRANT: begin
                // Early release and counter expiry both close the grant here
                if (release_pulse || (r_cnt == '0)) begin
                    w_grant_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = c_gap_load;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign grant      = r_grant;
    assign empty_seen = r_empty_seen;

endmodule : grant_decoder
`default_nettype wire

// File: doc/grant_decoder.md
GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, grant duration in cycles (legal 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, idle cycles forced between grants (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  encoded request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port in_idx  input  2  encoded channel index (priority-encoder dout).
REQ-008 SHALL have port in_zero  input  1  no-request flag (priority-encoder zero); in_idx ignored when 1.
REQ-009 SHALL have port release  input  1  early grant termination pulse.
REQ-010 SHALL have port grant  output  4  one-hot grant, bit in_idx set.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port empty_seen  output  1  one-cycle pulse when an in_zero=1 request is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-014 SHALL drive in_ready=1 only in IDLE, combinationally from state.
REQ-015 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; no other edge accepts.
REQ-016 SHALL, on acceptance with in_zero=0, enter GRANT, register grant = 1<<in_idx, load hold counter HOLD_CYCLES-1; grant visible the cycle after acceptance edge.
REQ-017 SHALL, on acceptance with in_zero=1, stay IDLE, keep grant=0, pulse empty_seen high for exactly the next cycle.
REQ-018 SHALL hold grant constant for exactly HOLD_CYCLES cycles in GRANT, decrementing counter each cycle; counter reaching 0 ends GRANT.
REQ-019 SHALL, when release=1 in GRANT, end GRANT at that edge (grant=0 the next cycle) regardless of counter.
REQ-020 SHALL ignore release outside GRANT.
REQ-021 SHALL, on GRANT exit, enter GAP with counter loaded GAP_CYCLES-1 and grant=0; if GAP_CYCLES=0, go directly to IDLE.
REQ-022 SHALL stay in GAP exactly GAP_CYCLES cycles, then IDLE.
REQ-023 SHALL guarantee grant is all-zero or exactly one-hot in every cycle.
REQ-024 SHALL ignore in_valid/in_idx/in_zero changes while in GRANT or GAP (no buffering, no queuing).
REQ-025 SHALL, with HOLD_CYCLES=1 and release=1 in the single GRANT cycle, still produce exactly one grant cycle.
REQ-026 SHALL size hold/gap counter at 4 bits; no wrap-around possible within legal parameters.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, force state IDLE, counter 0, grant=4'b0000, empty_seen=0; busy=0 and in_ready=1 follow the next cycle.
REQ-028 SHALL let rst take priority over acceptance, release and counter expiry on the same edge, including mid-GRANT or mid-GAP.

Structure
REQ-029 SHALL place state enum (IDLE/GRANT/GAP), IDX_W=2, GRANT_W=4, CNT_W=4 in shared package grant_decoder_pkg.
REQ-030 SHALL instantiate one combinational sub-module dec2to4 (2-bit index to 4-bit one-hot) feeding the grant register.

Verification
REQ-031 SHALL cover: reset, then in_valid=1, in_idx=2, in_zero=0 -> grant=4'b0100 for exactly 4 cycles, then 1 GAP cycle with busy=1, then in_ready=1.
REQ-032 SHALL cover: in_valid=1, in_zero=1, in_idx=3 in IDLE -> grant stays 0, empty_seen=1 one cycle, in_ready stays 1.
REQ-033 SHALL cover: grant of idx 0 active, release=1 in 2nd GRANT cycle -> grant=4'b0001 exactly 2 cycles, then GAP.
REQ-034 SHALL cover: in_valid held 1 with idx changing 3->1 during GRANT/GAP -> first grant 4'b1000 unaffected, next grant 4'b0010 accepted only in IDLE.
REQ-035 SHALL cover: rst=1 in 2nd cycle of grant 4'b1000 -> grant=0, busy=0 next cycle, in_ready=1.
REQ-036 SHALL cover: GAP_CYCLES=0, HOLD_CYCLES=1, back-to-back in_valid idx 0 then 1 -> grant 0001, IDLE one cycle, grant 0010; one-hot check every cycle.
